// File: rtl/seq_alu_core.sv
// seq_alu_core -- button-driven sequential ALU with a small register file.
//
// The operator keys in an opcode, operand A and operand B on the switches,
// pressing Button0 after each one. The core then executes (one cycle for
// simple ops, WIDTH cycles for the shift-add multiplier or the optional
// divider) and shows the result until the next press.
//
// Optional feature macro: SEQ_ALU_DIV_EN adds opcode 0101 = restoring divide.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-high reset
//   sw_i           [WIDTH+3:4] operand field, [3:0] opcode field
//   button0_i      enter key, acted on once per rising edge
//   button1_i      display select (1 = high half of result)
//   result_o       last computed result, 2*WIDTH bits
//   result_disp_o  selected half of result_o
//   valid_o        result is fresh (SHOW state)
//   busy_o         core is executing
//   error_o        illegal opcode, or divide by zero
//   carry_o        carry (ADD) or borrow (SUB)
//   state_o        FSM state code
module seq_alu_core #(
  parameter int WIDTH = 4,
  parameter int REGS  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH+3:0]     sw_i,
  input  logic                 button0_i,
  input  logic                 button1_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic [WIDTH-1:0]     result_disp_o,
  output logic                 valid_o,
  output logic                 busy_o,
  output logic                 error_o,
  output logic                 carry_o,
  output logic [2:0]           state_o
);

  localparam logic [2:0] GET_OP = 3'd0;
  localparam logic [2:0] GET_A  = 3'd1;
  localparam logic [2:0] GET_B  = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] SHOW   = 3'd4;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b0101;
  localparam logic [3:0] OP_MUL  = 4'b0111;
  localparam logic [3:0] OP_NAND = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_ST   = 4'b1111;

  localparam int AW = $clog2(REGS);
  localparam int CW = $clog2(WIDTH);

  logic [2:0]         state_q, state_d;
  logic               btn_prev_q;
  logic               press;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] result_q;
  logic               valid_q, error_q, carry_q;
  logic [WIDTH-1:0]   regfile_q [REGS];
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] prod_q, mcand_q, prod_n;
  logic [WIDTH-1:0]   mplier_q;
  logic [AW-1:0]      addr;
  logic               op_legal, multi_cycle, exec_done;
  logic [2*WIDTH-1:0] exec_result;
  logic               exec_carry, exec_err;
  logic [WIDTH:0]     sum;

`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH-1:0]   rem_q, quo_q, rem_n, quo_n;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
`endif

  assign press = button0_i & ~btn_prev_q;

  // Register address is A mod REGS; zero-extend when A is narrower than the index.
  if (WIDTH >= AW) begin : g_addr_slice
    assign addr = a_q[AW-1:0];
  end else begin : g_addr_ext
    assign addr = {{(AW-WIDTH){1'b0}}, a_q};
  end

  always_comb begin
    case (sw_i[3:0])
      OP_ADD, OP_SUB, OP_MUL, OP_NAND, OP_NOR, OP_XOR, OP_LD, OP_ST: op_legal = 1'b1;
`ifdef SEQ_ALU_DIV_EN
      OP_DIV:  op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  end

`ifdef SEQ_ALU_DIV_EN
  assign multi_cycle = (op_q == OP_MUL) || (op_q == OP_DIV);
  // Restoring step: shift next dividend bit into the partial remainder and
  // subtract B when it fits. The true difference is < B, so W bits suffice.
  assign div_sh = {rem_q, quo_q[WIDTH-1]};
  assign div_ge = (div_sh >= {1'b0, b_q});
  assign rem_n  = div_ge ? (div_sh[WIDTH-1:0] - b_q) : div_sh[WIDTH-1:0];
  assign quo_n  = {quo_q[WIDTH-2:0], div_ge};
`else
  assign multi_cycle = (op_q == OP_MUL);
`endif

  assign exec_done = !multi_cycle || (cnt_q == CW'(WIDTH - 1));
  // Final shift-add step is folded into the result so MUL takes exactly WIDTH cycles.
  assign prod_n    = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign sum       = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    exec_result = '0;
    exec_carry  = 1'b0;
    exec_err    = 1'b0;
    case (op_q)
      OP_ADD:  begin
        exec_result = {{(WIDTH-1){1'b0}}, sum};
        exec_carry  = sum[WIDTH];
      end
      OP_SUB:  begin
        exec_result = {{WIDTH{1'b0}}, a_q - b_q};
        exec_carry  = (a_q < b_q);
      end
      OP_NAND: exec_result = {{WIDTH{1'b0}}, ~(a_q & b_q)};
      OP_NOR:  exec_result = {{WIDTH{1'b0}}, ~(a_q | b_q)};
      OP_XOR:  exec_result = {{WIDTH{1'b0}}, a_q ^ b_q};
      OP_MUL:  exec_result = prod_n;
      OP_LD:   exec_result = {{WIDTH{1'b0}}, regfile_q[addr]};
      OP_ST:   exec_result = {{WIDTH{1'b0}}, b_q};
`ifdef SEQ_ALU_DIV_EN
      OP_DIV:  begin
        if (b_q == '0) begin
          exec_result = '1;
          exec_err    = 1'b1;
        end else begin
          exec_result = {rem_n, quo_n};
        end
      end
`endif
      default: ;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= GET_OP;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      GET_OP:  if (press && op_legal) state_d = GET_A;
      GET_A:   if (press) state_d = GET_B;
      GET_B:   if (press) state_d = EXEC;
      EXEC:    if (exec_done) state_d = SHOW;
      SHOW:    if (press) state_d = GET_OP;
      default: state_d = GET_OP;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o  = (state_q == EXEC);
    state_o = state_q;
  end

  // Datapath
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_prev_q <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      prod_q     <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      for (int i = 0; i < REGS; i++) regfile_q[i] <= '0;
`ifdef SEQ_ALU_DIV_EN
      rem_q      <= '0;
      quo_q      <= '0;
`endif
    end else begin
      btn_prev_q <= button0_i;
      case (state_q)
        GET_OP: if (press) begin
          op_q <= sw_i[3:0];
          if (op_legal) begin
            error_q <= 1'b0;
            valid_q <= 1'b0;
          end else begin
            error_q <= 1'b1;
          end
        end
        GET_A: if (press) a_q <= sw_i[WIDTH+3:4];
        GET_B: if (press) begin
          b_q      <= sw_i[WIDTH+3:4];
          cnt_q    <= '0;
          prod_q   <= '0;
          mcand_q  <= {{WIDTH{1'b0}}, a_q};
          mplier_q <= sw_i[WIDTH+3:4];
`ifdef SEQ_ALU_DIV_EN
          rem_q    <= '0;
          quo_q    <= a_q;
`endif
        end
        EXEC: begin
          cnt_q    <= cnt_q + CW'(1);
          prod_q   <= prod_n;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
`ifdef SEQ_ALU_DIV_EN
          rem_q    <= rem_n;
          quo_q    <= quo_n;
`endif
          if (exec_done) begin
            result_q <= exec_result;
            carry_q  <= exec_carry;
            valid_q  <= 1'b1;
            if (exec_err) error_q <= 1'b1;
            if (op_q == OP_ST) regfile_q[addr] <= b_q;
          end
        end
        SHOW: if (press) valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign result_o      = result_q;
  assign valid_o       = valid_q;
  assign error_o       = error_q;
  assign carry_o       = carry_q;
  assign result_disp_o = button1_i ? result_q[2*WIDTH-1:WIDTH] : result_q[WIDTH-1:0];

endmodule
